// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch and next-PC stage feeding the instruction decoder.
// Owns the PC, fetches over a req/ack handshake with variable-latency memory,
// holds each instruction for one execute window and then selects the next PC
// from the decoder's jump/branch controls and the ALU zero flag.
//
// Optional feature: define IFU_MISALIGN_TRAP_EN to trap on a misaligned
// next PC (sticky misalign_o, TRAP state exited only by reset). Without it
// the raw next PC is loaded and misalign_o is tied low.

module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] instr_o,
    output logic        instr_valid_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o,
    input  logic        exec_hold_i,
    input  logic        branch_i,
    input  logic        branch_type_i,
    input  logic [1:0]  jump_i,
    input  logic        zero_i,
    input  logic [31:0] jr_addr_i,
    output logic        misalign_o
);

`ifdef IFU_MISALIGN_TRAP_EN
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        TRAP  = 2'd3
    } fetchState_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2
    } fetchState_t;
`endif

    fetchState_t state;

    logic [31:0] pcReg;
    logic [31:0] instrReg;
    logic        reqReg;
    logic        validReg;

    logic [31:0] pcPlus4;
    logic [31:0] jumpTarget;
    logic [31:0] branchOffset;
    logic [31:0] branchTarget;
    logic        branchTaken;
    logic [31:0] nextPc;

    assign pcPlus4       = pcReg + 32'd4;
    assign imem_req_o    = reqReg;
    assign imem_addr_o   = pcReg;
    assign instr_o       = instrReg;
    assign instr_valid_o = validReg;
    assign pc_o          = pcReg;
    assign pc_plus4_o    = pcPlus4;

    // Next-PC selection: Jr beats J/Jal beats a taken branch; jump code 3 is
    // treated like "no jump" and falls through to the branch/sequential path.
    always_comb begin
        jumpTarget   = {pcPlus4[31:28], instrReg[25:0], 2'b00};
        branchOffset = {{14{instrReg[15]}}, instrReg[15:0], 2'b00};
        branchTarget = pcPlus4 + branchOffset;
        branchTaken  = branch_i & (branch_type_i ? ~zero_i : zero_i);
        nextPc       = pcPlus4;
        if (jump_i == 2'd2) begin
            nextPc = jr_addr_i;
        end else if (jump_i == 2'd1) begin
            nextPc = jumpTarget;
        end else if (branchTaken) begin
            nextPc = branchTarget;
        end
    end

`ifdef IFU_MISALIGN_TRAP_EN
    logic misalignReg;
    assign misalign_o = misalignReg;
`else
    assign misalign_o = 1'b0;
`endif

    // Fetch FSM: IDLE gives memory one req-low cycle, FETCH waits for ack
    // with no timeout, EXEC holds the instruction until execute releases it.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state    <= IDLE;
            pcReg    <= RESET_PC;
            instrReg <= '0;
            reqReg   <= 1'b0;
            validReg <= 1'b0;
`ifdef IFU_MISALIGN_TRAP_EN
            misalignReg <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    state  <= FETCH;
                    reqReg <= 1'b1;
                end
                FETCH: begin
                    if (imem_ack_i) begin
                        instrReg <= imem_rdata_i;
                        state    <= EXEC;
                        reqReg   <= 1'b0;
                        validReg <= 1'b1;
                    end
                end
                EXEC: begin
                    if (!exec_hold_i) begin
`ifdef IFU_MISALIGN_TRAP_EN
                        if (nextPc[1:0] != 2'b00) begin
                            misalignReg <= 1'b1;
                            state       <= TRAP;
                            reqReg      <= 1'b0;
                            validReg    <= 1'b0;
                        end else begin
                            pcReg    <= nextPc;
                            state    <= FETCH;
                            reqReg   <= 1'b1;
                            validReg <= 1'b0;
                        end
`else
                        pcReg    <= nextPc;
                        state    <= FETCH;
                        reqReg   <= 1'b1;
                        validReg <= 1'b0;
`endif
                    end
                end
`ifdef IFU_MISALIGN_TRAP_EN
                TRAP: begin
                    reqReg   <= 1'b0;
                    validReg <= 1'b0;
                end
`else
                default: begin
                    state    <= IDLE;
                    reqReg   <= 1'b0;
                    validReg <= 1'b0;
                end
`endif
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: self-checking bench for instr_fetch_unit. The bench
// plays instruction memory, drives the decoder controls and compares the
// PC/instruction outputs against a next-PC reference model.

module tb_instr_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i = 1'b0;
    logic [31:0] imem_rdata_i = '0;
    logic [31:0] instr_o;
    logic        instr_valid_o;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4_o;
    logic        exec_hold_i = 1'b0;
    logic        branch_i = 1'b0;
    logic        branch_type_i = 1'b0;
    logic [1:0]  jump_i = 2'd0;
    logic        zero_i = 1'b0;
    logic [31:0] jr_addr_i = '0;
    logic        misalign_o;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] expPc = RESET_PC;

    typedef struct {
        string       name;
        logic [31:0] startPc;
        logic [31:0] instr;
        logic        branch;
        logic        btype;
        logic [1:0]  jump;
        logic        zero;
        logic [31:0] jr;
        logic [31:0] expPc;
    } vec_t;

    vec_t vecs[9];

    instr_fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ack_i    (imem_ack_i),
        .imem_rdata_i  (imem_rdata_i),
        .instr_o       (instr_o),
        .instr_valid_o (instr_valid_o),
        .pc_o          (pc_o),
        .pc_plus4_o    (pc_plus4_o),
        .exec_hold_i   (exec_hold_i),
        .branch_i      (branch_i),
        .branch_type_i (branch_type_i),
        .jump_i        (jump_i),
        .zero_i        (zero_i),
        .jr_addr_i     (jr_addr_i),
        .misalign_o    (misalign_o)
    );

    always #5 clk_i = ~clk_i;

    // Hard stop in case something upstream of the bounded waits hangs.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic checkBit(input string name, input logic actual, input logic expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %b expected %b", name, actual, expected);
        end
    endtask

    // Reference next-PC rule written as plain arithmetic on the PC value.
    function automatic logic [31:0] refNextPc(input logic [31:0] pc, input logic [31:0] instr,
                                              input logic br, input logic bt, input logic [1:0] jmp,
                                              input logic zr, input logic [31:0] jr);
        logic [31:0] seq;
        int          offsetWords;
        seq = pc + 32'd4;
        if (jmp == 2'd2) return jr;
        if (jmp == 2'd1) return (seq & 32'hF000_0000) | ((instr & 32'h03FF_FFFF) * 32'd4);
        offsetWords = int'($signed(instr[15:0]));
        if (br && (bt ? !zr : zr)) return seq + 32'(offsetWords * 4);
        return seq;
    endfunction

    // Controls must be ignored outside EXEC, so they carry junk while fetching.
    task automatic scrambleControls();
        exec_hold_i   = 1'($urandom);
        branch_i      = 1'($urandom);
        branch_type_i = 1'($urandom);
        jump_i        = 2'($urandom);
        zero_i        = 1'($urandom);
        jr_addr_i     = $urandom;
    endtask

    task automatic doReset();
        rst_i      = 1'b0;
        imem_ack_i = 1'b0;
        scrambleControls();
        repeat (2) @(negedge clk_i);
        checkBit("resetReq", imem_req_o, 1'b0);
        checkBit("resetValid", instr_valid_o, 1'b0);
        checkBit("resetMisalign", misalign_o, 1'b0);
        checkOutput("resetPc", pc_o, RESET_PC);
        checkOutput("resetAddr", imem_addr_o, RESET_PC);
        checkOutput("resetPlus4", pc_plus4_o, RESET_PC + 32'd4);
        checkOutput("resetInstr", instr_o, 32'h0);
        rst_i = 1'b1;
        expPc = RESET_PC;
    endtask

    task automatic fetchInstr(input logic [31:0] word, input int delay);
        int waitCnt;
        waitCnt = 0;
        while (imem_req_o !== 1'b1 && waitCnt < 20) begin
            scrambleControls();
            @(negedge clk_i);
            waitCnt++;
        end
        if (imem_req_o !== 1'b1) begin
            checks++;
            errors++;
            $display("[TB] FAIL reqTimeout: got req=%b expected 1 within 20 cycles", imem_req_o);
            return;
        end
        for (int d = 0; d < delay; d++) begin
            checkBit("reqWhileWaiting", imem_req_o, 1'b1);
            checkOutput("addrWhileWaiting", imem_addr_o, expPc);
            imem_ack_i   = 1'b0;
            imem_rdata_i = $urandom;
            scrambleControls();
            @(negedge clk_i);
        end
        checkOutput("fetchAddr", imem_addr_o, expPc);
        imem_ack_i   = 1'b1;
        imem_rdata_i = word;
        scrambleControls();
        @(negedge clk_i);
        imem_ack_i   = 1'b0;
        imem_rdata_i = $urandom;
        checkBit("execValid", instr_valid_o, 1'b1);
        checkBit("execReq", imem_req_o, 1'b0);
        checkOutput("execInstr", instr_o, word);
        checkOutput("execPc", pc_o, expPc);
        checkOutput("execPlus4", pc_plus4_o, expPc + 32'd4);
    endtask

    task automatic execInstr(input logic [31:0] word, input int hold, input logic br, input logic bt,
                             input logic [1:0] jmp, input logic zr, input logic [31:0] jr);
        logic [31:0] newPc;
        for (int h = 0; h < hold; h++) begin
            scrambleControls();
            exec_hold_i = 1'b1;
            @(negedge clk_i);
            checkBit("holdValid", instr_valid_o, 1'b1);
            checkOutput("holdPc", pc_o, expPc);
            checkOutput("holdInstr", instr_o, word);
        end
        exec_hold_i   = 1'b0;
        branch_i      = br;
        branch_type_i = bt;
        jump_i        = jmp;
        zero_i        = zr;
        jr_addr_i     = jr;
        newPc = refNextPc(expPc, word, br, bt, jmp, zr, jr);
        @(negedge clk_i);
        scrambleControls();
        checkBit("afterExecValid", instr_valid_o, 1'b0);
`ifdef IFU_MISALIGN_TRAP_EN
        if (newPc[1:0] != 2'b00) begin
            checkBit("trapMisalign", misalign_o, 1'b1);
            checkBit("trapReq", imem_req_o, 1'b0);
            checkOutput("trapPc", pc_o, expPc);
        end else begin
            checkBit("nextReq", imem_req_o, 1'b1);
            checkOutput("nextPc", pc_o, newPc);
            checkOutput("nextAddr", imem_addr_o, newPc);
            checkBit("noMisalign", misalign_o, 1'b0);
            expPc = newPc;
        end
`else
        checkBit("nextReq", imem_req_o, 1'b1);
        checkOutput("nextPc", pc_o, newPc);
        checkOutput("nextAddr", imem_addr_o, newPc);
        checkBit("noMisalign", misalign_o, 1'b0);
        expPc = newPc;
`endif
    endtask

    task automatic applyStimulus(input logic [31:0] word, input int delay, input int hold,
                                 input logic br, input logic bt, input logic [1:0] jmp,
                                 input logic zr, input logic [31:0] jr);
        fetchInstr(word, delay);
        execInstr(word, hold, br, bt, jmp, zr, jr);
    endtask

    task automatic jumpTo(input logic [31:0] target);
        applyStimulus(32'h0000_0008, 0, 0, 1'b0, 1'b0, 2'd2, 1'b0, target);
    endtask

    initial begin
        vecs[0] = '{"beqTaken",    32'h0000_0010, 32'h1000_0003, 1'b1, 1'b0, 2'd0, 1'b1, 32'h0, 32'h0000_0020};
        vecs[1] = '{"bneNotTaken", 32'h0000_0010, 32'h1400_0003, 1'b1, 1'b1, 2'd0, 1'b1, 32'h0, 32'h0000_0014};
        vecs[2] = '{"beqBackward", 32'h0000_0010, 32'h1000_FFFF, 1'b1, 1'b0, 2'd0, 1'b1, 32'h0, 32'h0000_0010};
        vecs[3] = '{"jump",        32'h1000_0000, 32'h0800_0040, 1'b0, 1'b0, 2'd1, 1'b0, 32'h0, 32'h1000_0100};
        vecs[4] = '{"jrOverBr",    32'h0000_0100, 32'h1000_0003, 1'b1, 1'b0, 2'd2, 1'b1, 32'h44, 32'h0000_0044};
        vecs[5] = '{"jumpCode3",   32'h0000_0020, 32'h0800_0040, 1'b0, 1'b0, 2'd3, 1'b0, 32'h0, 32'h0000_0024};
        vecs[6] = '{"pcWrap",      32'hFFFF_FFFC, 32'h0000_0020, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0000_0000};
        vecs[7] = '{"beqNotTaken", 32'h0000_0030, 32'h1000_0003, 1'b1, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0000_0034};
        vecs[8] = '{"jumpTopBits", 32'hF000_0000, 32'h0BFF_FFFF, 1'b0, 1'b0, 2'd1, 1'b0, 32'h0, 32'hFFFF_FFFC};

        doReset();

        // Sequential add stream with a 3-cycle ack delay at pc 8.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(32'h0128_5020 + 32'(i), (i == 2) ? 3 : 0, 0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0);
            checkOutput("seqPc", pc_o, 32'(i * 4 + 4));
        end

        // Execute held for two extra cycles: valid high three cycles total.
        applyStimulus(32'h0128_5020, 0, 2, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0);
        checkOutput("holdNextPc", pc_o, 32'h0000_0014);

        // Reset while waiting in FETCH, then a stale ack during IDLE.
        checkBit("preResetReq", imem_req_o, 1'b1);
        doReset();
        imem_ack_i   = 1'b1;
        imem_rdata_i = 32'hDEAD_BEEF;
        @(negedge clk_i);
        imem_ack_i = 1'b0;
        checkBit("staleAckValid", instr_valid_o, 1'b0);
        checkBit("staleAckReq", imem_req_o, 1'b1);
        checkOutput("staleAckInstr", instr_o, 32'h0);
        checkOutput("staleAckPc", pc_o, RESET_PC);

        // Directed next-PC vectors.
        foreach (vecs[i]) begin
            jumpTo(vecs[i].startPc);
            applyStimulus(vecs[i].instr, 1, 0, vecs[i].branch, vecs[i].btype,
                          vecs[i].jump, vecs[i].zero, vecs[i].jr);
            checkOutput(vecs[i].name, pc_o, vecs[i].expPc);
        end

        // Randomized instruction stream with aligned Jr targets.
        for (int n = 0; n < 40; n++) begin
            applyStimulus($urandom, $urandom_range(0, 3), $urandom_range(0, 2),
                          1'($urandom), 1'($urandom), 2'($urandom_range(0, 3)),
                          1'($urandom), $urandom & 32'hFFFF_FFFC);
        end

        // Misaligned Jr target.
        jumpTo(32'h0000_0040);
        applyStimulus(32'h0000_0008, 0, 0, 1'b0, 1'b0, 2'd2, 1'b0, 32'h0000_0046);
`ifdef IFU_MISALIGN_TRAP_EN
        for (int t = 0; t < 3; t++) begin
            @(negedge clk_i);
            checkBit("trapStaysReq", imem_req_o, 1'b0);
            checkBit("trapStaysValid", instr_valid_o, 1'b0);
            checkBit("trapSticky", misalign_o, 1'b1);
            checkOutput("trapStaysPc", pc_o, 32'h0000_0040);
        end
        doReset();
`else
        checkOutput("rawMisalignPc", pc_o, 32'h0000_0046);
        checkOutput("rawMisalignAddr", imem_addr_o, 32'h0000_0046);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
